// File: rtl/note_seq_pkg.sv
// Shared types and ROM word layout for the note sequencer and the tone generator.
// Word layout is {pitch, dur}; positions below describe the default 6+10 bit word.
// Pitch code 0 is a rest and never drives the tone generator.
package note_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      PLAY  = 2'd3
   } state_t;

   localparam int PITCH_REST = 0;

   localparam int DEF_PITCH_W = 6;
   localparam int DEF_DUR_W   = 10;

   localparam int DUR_LSB   = 0;
   localparam int DUR_MSB   = DUR_LSB + DEF_DUR_W - 1;
   localparam int PITCH_LSB = DUR_MSB + 1;
   localparam int PITCH_MSB = PITCH_LSB + DEF_PITCH_W - 1;

endpackage

// File: rtl/note_timer.sv
// Per-note tick down-counter with a pending-tick flag for ticks seen during fetch.
// Latency: dec/zero/in_gap are combinational views of this clock's update.
// Backpressure: none; ticks arriving while not running are held in one flag.
module note_timer
   import note_seq_pkg::*;
#(
   parameter int DUR_W     = DEF_DUR_W,
   parameter int GAP_TICKS = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             flush,
   input  logic             load,
   input  logic [DUR_W-1:0] dur,
   input  logic             hold,
   input  logic             run,
   input  logic             tick,
   output logic             dec,
   output logic             zero,
   output logic             in_gap
);

   logic [DUR_W-1:0] remaining;
   logic [DUR_W-1:0] rem_dec;
   logic             pending;
   logic             short_note;

   // A held tick is spent on the first running cycle, keeping note length exact.
   assign dec     = run & (tick | pending);
   assign rem_dec = remaining - 1'b1;

   // Both flags describe the count as it will stand after this clock.
   assign zero   = dec && (remaining == DUR_W'(1));
   assign in_gap = dec && !short_note && (rem_dec <= DUR_W'(GAP_TICKS));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         remaining  <= '0;
         pending    <= 1'b0;
         short_note <= 1'b0;
      end else if (flush) begin
         remaining  <= '0;
         pending    <= 1'b0;
         short_note <= 1'b0;
      end else begin
         if (load) begin
            remaining  <= dur;
            short_note <= (dur <= DUR_W'(GAP_TICKS));
         end else if (dec) begin
            remaining <= rem_dec;
         end

         if (hold) begin
            pending <= 1'b1;
         end else if (dec) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Walks a note ROM, holding each word's pitch for its duration in tempo ticks.
// Latency: play->FETCH 1 clk, data latched in LOAD, pitch/sounding valid 3 clks after play.
// Backpressure: play=0 pauses to IDLE; ticks during FETCH/LOAD are kept as one pending tick.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int PITCH_W   = DEF_PITCH_W,
   parameter int DUR_W     = DEF_DUR_W,
   parameter int GAP_TICKS = 5
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     tick,
   input  logic                     play,
   input  logic                     restart,
   input  logic                     loop,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [PITCH_W+DUR_W-1:0] rom_data,
   output logic [PITCH_W-1:0]       pitch,
   output logic                     sounding,
   output logic                     busy,
   output logic                     done
);

   state_t              state;
   state_t              state_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [PITCH_W-1:0]  pitch_d;
   logic                sounding_d;
   logic                done_d;

   logic [DUR_W-1:0]    word_dur;
   logic [PITCH_W-1:0]  word_pitch;

   logic                t_flush;
   logic                t_load;
   logic                t_hold;
   logic                t_run;
   logic                t_dec;
   logic                t_zero;
   logic                t_in_gap;

   assign word_dur   = rom_data[DUR_LSB +: DUR_W];
   assign word_pitch = rom_data[DUR_LSB + DUR_W +: PITCH_W];

   // Ticks coincident with restart or pause are dropped, never held or counted.
   assign t_hold = tick & play & ~restart & ((state == FETCH) | (state == LOAD));
   assign t_run  = play & ~restart & (state == PLAY);

   note_timer #(
      .DUR_W     (DUR_W),
      .GAP_TICKS (GAP_TICKS)
   ) u_timer (
      .clk    (clk),
      .clr    (clr),
      .flush  (t_flush),
      .load   (t_load),
      .dur    (word_dur),
      .hold   (t_hold),
      .run    (t_run),
      .tick   (tick),
      .dec    (t_dec),
      .zero   (t_zero),
      .in_gap (t_in_gap)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         rom_addr <= '0;
         pitch    <= '0;
         sounding <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         rom_addr <= addr_d;
         pitch    <= pitch_d;
         sounding <= sounding_d;
         busy     <= (state_d != IDLE);
         done     <= done_d;
      end
   end

   always_comb begin
      state_d    = state;
      addr_d     = rom_addr;
      pitch_d    = pitch;
      sounding_d = sounding;
      done_d     = 1'b0;
      t_flush    = 1'b0;
      t_load     = 1'b0;

      if (restart) begin
         state_d    = IDLE;
         addr_d     = '0;
         pitch_d    = '0;
         sounding_d = 1'b0;
         t_flush    = 1'b0 | 1'b1;
      end else if (!play && (state != IDLE)) begin
         // Pause keeps the address so the interrupted word replays from its start.
         state_d    = IDLE;
         pitch_d    = '0;
         sounding_d = 1'b0;
         t_flush    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (play) begin
                  state_d = FETCH;
               end
            end

            FETCH: begin
               state_d = LOAD;
            end

            LOAD: begin
               if (word_dur == '0) begin
                  addr_d = '0;
                  if (loop) begin
                     state_d = FETCH;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     t_flush = 1'b1;
                  end
               end else begin
                  t_load     = 1'b1;
                  pitch_d    = word_pitch;
                  sounding_d = (word_pitch != PITCH_W'(PITCH_REST));
                  state_d    = PLAY;
               end
            end

            PLAY: begin
               if (t_dec) begin
                  if (t_zero) begin
                     addr_d     = rom_addr + 1'b1;
                     pitch_d    = '0;
                     sounding_d = 1'b0;
                     state_d    = FETCH;
                  end else begin
                     sounding_d = (pitch != PITCH_W'(PITCH_REST)) && !t_in_gap;
                  end
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a registered ROM model and immediate assertions.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic        tick;
   logic        play;
   logic        restart;
   logic        loop;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [5:0]  pitch;
   logic        sounding;
   logic        busy;
   logic        done;

   logic [15:0] rom [0:255];

   int n_cmp = 0;
   int n_bad = 0;

   bit         mon = 1'b0;
   int         done_cnt;
   int         busy_lo;
   logic [7:0] last_addr;
   logic [7:0] alog [$];

   int hi;
   int cnt;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   note_sequencer #(
      .ADDR_W    (8),
      .PITCH_W   (6),
      .DUR_W     (10),
      .GAP_TICKS (5)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .tick     (tick),
      .play     (play),
      .restart  (restart),
      .loop     (loop),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .pitch    (pitch),
      .sounding (sounding),
      .busy     (busy),
      .done     (done)
   );

   function automatic logic [15:0] w(input int p, input int d);
      return {p[5:0], d[9:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic cyc();
      @(negedge clk);
      if (mon) begin
         if (done) done_cnt++;
         if (!busy) busy_lo++;
         if (rom_addr != last_addr) begin
            alog.push_back(rom_addr);
            last_addr = rom_addr;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic tk();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   initial begin
      int exp_seq [6];
      exp_seq = '{1, 2, 0, 1, 2, 0};

      clr = 1'b1; tick = 1'b0; play = 1'b0; restart = 1'b0; loop = 1'b0;
      clear_rom();
      repeat (2) @(negedge clk);
      chk("rst_addr",     32'(rom_addr), 0);
      chk("rst_pitch",    32'(pitch),    0);
      chk("rst_sounding", 32'(sounding), 0);
      chk("rst_busy",     32'(busy),     0);
      chk("rst_done",     32'(done),     0);
      clr = 1'b0;
      cyc();

      // Single 100-tick note followed by end marker, loop off.
      rom[0] = w(12, 100); rom[1] = w(0, 0);
      play = 1'b1;
      cyc();
      chk("t1_fetch_busy", 32'(busy), 1);
      chk("t1_fetch_addr", 32'(rom_addr), 0);
      cyc();
      chk("t1_load_pitch", 32'(pitch), 0);
      cyc();
      chk("t1_play_pitch", 32'(pitch), 12);
      hi = 0; cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (sounding) hi++;
         if (pitch == 6'd12) cnt++;
         idle(3);
         tk();
      end
      chk("t1_sound_ticks", 32'(hi), 95);
      chk("t1_pitch_ticks", 32'(cnt), 100);
      chk("t1_next_addr",   32'(rom_addr), 1);
      chk("t1_fetch_pitch", 32'(pitch), 0);
      cyc();
      chk("t1_load_nodone", 32'(done), 0);
      cyc();
      chk("t1_done",      32'(done), 1);
      chk("t1_busy_fall", 32'(busy), 0);
      chk("t1_addr_zero", 32'(rom_addr), 0);
      play = 1'b0;
      cyc();
      chk("t1_done_pulse", 32'(done), 0);

      // Leading rest, then a short note that must sound with no gap.
      clear_rom();
      rom[0] = w(0, 50); rom[1] = w(7, 3); rom[2] = w(0, 0);
      play = 1'b1;
      idle(3);
      hi = 0; cnt = 0;
      for (int k = 0; k < 50; k++) begin
         if (sounding) hi++;
         if (pitch != 6'd0) cnt++;
         idle(3);
         tk();
      end
      chk("t2_rest_sound", 32'(hi), 0);
      chk("t2_rest_pitch", 32'(cnt), 0);
      chk("t2_addr1",      32'(rom_addr), 1);
      idle(2);
      chk("t2_short_pitch", 32'(pitch), 7);
      hi = 0;
      for (int k = 0; k < 3; k++) begin
         if (sounding) hi++;
         idle(3);
         tk();
      end
      chk("t2_short_sound", 32'(hi), 3);
      chk("t2_addr2",       32'(rom_addr), 2);
      idle(2);
      chk("t2_done", 32'(done), 1);
      play = 1'b0;
      cyc();

      // Looping song: address walks 0,1,2,0,... with no done and busy held.
      clear_rom();
      rom[0] = w(5, 20); rom[1] = w(9, 20); rom[2] = w(0, 0);
      loop = 1'b1; play = 1'b1;
      done_cnt = 0; busy_lo = 0; last_addr = 8'd0; alog.delete();
      mon = 1'b1;
      idle(3);
      repeat (80) begin
         idle(3);
         tk();
      end
      idle(3);
      mon = 1'b0;
      chk("t3_log_len", 32'(alog.size()), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < alog.size()) chk($sformatf("t3_seq%0d", i), 32'(alog[i]), 32'(exp_seq[i]));
      end
      chk("t3_no_done", 32'(done_cnt), 0);
      chk("t3_busy_hi", 32'(busy_lo), 0);
      restart = 1'b1; play = 1'b0;
      cyc();
      restart = 1'b0; loop = 1'b0;
      chk("t3_stop_addr", 32'(rom_addr), 0);
      chk("t3_stop_busy", 32'(busy), 0);

      // Tick landing in FETCH counts toward the note.
      clear_rom();
      rom[0] = w(12, 100); rom[1] = w(0, 0);
      play = 1'b1;
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      chk("t4_pitch", 32'(pitch), 12);
      for (int k = 1; k < 100; k++) begin
         idle(3);
         tk();
         if (k == 98) begin
            chk("t4_addr_at98",  32'(rom_addr), 0);
            chk("t4_pitch_at98", 32'(pitch), 12);
         end
      end
      chk("t4_addr_end", 32'(rom_addr), 1);
      idle(2);
      chk("t4_done", 32'(done), 1);
      play = 1'b0;
      cyc();

      // Pause 40 ticks into the second word, then resume and replay it fully.
      clear_rom();
      rom[0] = w(1, 2); rom[1] = w(12, 100); rom[2] = w(0, 0);
      play = 1'b1;
      idle(3);
      repeat (2) begin idle(3); tk(); end
      repeat (40) begin idle(3); tk(); end
      chk("t5_pre_pitch", 32'(pitch), 12);
      chk("t5_pre_sound", 32'(sounding), 1);
      play = 1'b0;
      cyc();
      chk("t5_pause_busy",  32'(busy), 0);
      chk("t5_pause_pitch", 32'(pitch), 0);
      chk("t5_pause_sound", 32'(sounding), 0);
      chk("t5_pause_addr",  32'(rom_addr), 1);
      idle(2);
      play = 1'b1;
      cyc();
      chk("t5_refetch_addr", 32'(rom_addr), 1);
      idle(2);
      chk("t5_resume_pitch", 32'(pitch), 12);
      hi = 0;
      for (int k = 0; k < 100; k++) begin
         if (sounding) hi++;
         idle(3);
         tk();
      end
      chk("t5_full_sound", 32'(hi), 95);
      chk("t5_end_addr",   32'(rom_addr), 2);
      idle(2);
      chk("t5_done", 32'(done), 1);
      play = 1'b0;
      cyc();

      // Asynchronous clear between clock edges mid-note.
      play = 1'b1;
      idle(3);
      repeat (2) begin idle(3); tk(); end
      repeat (10) begin idle(3); tk(); end
      #2 clr = 1'b1;
      #1;
      chk("t6_clr_addr",  32'(rom_addr), 0);
      chk("t6_clr_pitch", 32'(pitch), 0);
      chk("t6_clr_sound", 32'(sounding), 0);
      chk("t6_clr_busy",  32'(busy), 0);
      chk("t6_clr_done",  32'(done), 0);
      play = 1'b0;
      cyc();
      clr = 1'b0;
      cyc();

      // Restart coincident with a tick: tick must not carry into the next note.
      play = 1'b1;
      idle(3);
      repeat (2) begin idle(3); tk(); end
      repeat (5) begin idle(3); tk(); end
      idle(3);
      tick = 1'b1; restart = 1'b1;
      cyc();
      tick = 1'b0; restart = 1'b0;
      chk("t7_rst_addr",  32'(rom_addr), 0);
      chk("t7_rst_busy",  32'(busy), 0);
      chk("t7_rst_pitch", 32'(pitch), 0);
      chk("t7_rst_sound", 32'(sounding), 0);
      idle(3);
      chk("t7_replay_pitch", 32'(pitch), 1);
      idle(3);
      tk();
      chk("t7_tick_dropped", 32'(rom_addr), 0);
      idle(3);
      tk();
      chk("t7_note_end", 32'(rom_addr), 1);
      play = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Consumes the one-cycle tempo `tick` from the tempo pulse generator, where 100 ticks make one quarter note. Walks a note ROM word by word and holds each note's pitch code for that word's duration in ticks. Inserts a short articulation gap at the end of each note, then advances to the next word. Its outputs drive the tone generator, which turns `pitch` into an audio square wave while `sounding` is high.

## Interface
Parameters:
- `ADDR_W`, 8: ROM address width (max 256 words).
- `PITCH_W`, 6: pitch code width; code 0 = rest.
- `DUR_W`, 10: duration field width, in ticks.
- `GAP_TICKS`, 5: silent ticks at the end of each note.

Ports:
- `clk`  in  1: system clock.
- `clr`  in  1: reset, asynchronous, active-high.
- `tick`  in  1: tempo enable; one-cycle pulse, period ≥ 4 clocks.
- `play`  in  1: level; 1 = run, 0 = pause.
- `restart`  in  1: one-cycle pulse; return to address 0 and go idle.
- `loop`  in  1: level; on end marker, 1 = wrap to 0, 0 = stop.
- `rom_addr`  out  ADDR_W: registered ROM address.
- `rom_data`  in  PITCH_W+DUR_W: word `{pitch, dur}`, valid one clock after `rom_addr`.
- `pitch`  out  PITCH_W: current pitch code; 0 when not playing a note.
- `sounding`  out  1: tone enable.
- `busy`  out  1: 1 in any state except IDLE.
- `done`  out  1: one-cycle pulse when the song ends with `loop`=0.

## Operation
- Reset values: `rom_addr`=0, `pitch`=0, `sounding`=0, `busy`=0, `done`=0, state IDLE, tick counter 0, pending-tick flag 0.
- States:
  - IDLE: when `play`=1 → FETCH.
  - FETCH: `rom_addr` stable this cycle → LOAD.
  - LOAD: latch `rom_data`.
    - `dur`=0 is the end marker (pitch ignored): `loop`=1 → `rom_addr`←0, FETCH; else `done`=1 for one cycle, `rom_addr`←0, IDLE.
    - Otherwise: `pitch`←word pitch, `remaining`←dur, PLAY.
  - PLAY: each tick decrements `remaining`. The tick that makes `remaining`=0 does `rom_addr`←`rom_addr`+1 and → FETCH.
- Sounding and gap:
  - `sounding`=1 in PLAY iff `pitch`≠0 and (`remaining` > GAP_TICKS or dur ≤ GAP_TICKS).
  - A note with dur ≤ GAP_TICKS sounds for its full length with no gap.
  - `pitch` holds through the gap and is cleared to 0 in FETCH.
- Pending tick: a tick arriving in FETCH or LOAD sets the flag. The flag is consumed as a decrement on the first PLAY cycle, so no tick is lost and each note lasts exactly dur ticks.
- Address wrap: incrementing from 2^ADDR_W−1 wraps to 0 and continues, regardless of `loop`.
- Pause: `play`=0 in any non-IDLE state → IDLE next edge.
  - `pitch`←0, `sounding`←0, pending flag cleared, `rom_addr` held.
  - When resumed, the current word is re-fetched and plays from its start.
- Priority, highest first: `clr` > `restart` > `play`=0 > tick.
  - `restart`: `rom_addr`←0, IDLE, outputs as at reset.
  - A tick coincident with `restart` or pause is discarded.

## Timing
- `play` rising edge in IDLE: `rom_addr` valid in FETCH (cycle 1), data latched in LOAD (cycle 2), `pitch`/`sounding` valid from cycle 3.
- Note-to-note overhead is 2 clocks (FETCH, LOAD). Tempo is unaffected because of the pending tick.
- `done` is asserted in the cycle after LOAD reads the end marker, coincident with `busy` falling.
- `clr` clears all registers immediately, with no clock edge needed.
- All outputs are registered.

## Structure
- Shared package `note_seq_pkg`:
  - state enum (IDLE, FETCH, LOAD, PLAY);
  - `PITCH_REST`=0;
  - field positions `PITCH_MSB/LSB` and `DUR_MSB/LSB` of the ROM word.
- The tone generator imports the same package.
- Sub-module `note_timer`: DUR_W down-counter with load, tick decrement, pending-tick flag, `zero` and `in_gap` flags.
- The sequencer FSM and address register stay in the top module.

## Test plan
- ROM {12,100},{0,0}, `play`=1, `loop`=0: `rom_addr` 0 then 1; `pitch`=12 for 100 ticks; `sounding` high 95 ticks, low 5; `done` pulses once; `busy`→0; `rom_addr`=0.
- ROM {0,50},{7,3},{0,0}: `sounding`=0 for 50 ticks with `pitch`=0; then `pitch`=7 with `sounding`=1 for all 3 ticks (no gap).
- ROM {5,20},{9,20},{0,0} with `loop`=1: `rom_addr` sequence 0,1,2,0,1,…; `done` never asserts; `busy` stays 1.
- Tick forced in the FETCH cycle of note {12,100}: note ends after exactly 100 ticks, counted from the FETCH tick.
- `play` dropped after 40 ticks of {12,100}: IDLE next edge, `pitch`=0, `rom_addr` held. `play` reasserted: word re-fetched and plays the full 100 ticks.
- `clr` pulsed between clock edges mid-note: all outputs at reset values before the next edge. `restart` coincident with a tick: `rom_addr`=0, IDLE, tick discarded.
